// File: rtl/mux_pkg.sv
// Shared mode encodings and width helper for the N:1 stream multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from ptr+1 upward.
// Latency: grant is combinational; ptr moves one cycle after an advance. No backpressure of its own.
// Backpressure: none; the caller decides when a grant is consumed via advance.
module mux_rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = sel_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] grant_idx
);

    logic [SW-1:0] r_ptr;
    logic          w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (int'(r_ptr) + k) % N;
            if (!w_found && req[c]) begin
                w_found   = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = SW'(c);
            end
        end
    end

    // Reset pointer to the last channel so channel 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= SW'(N - 1);
        end else if (advance && w_found) begin
            r_ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/mux_nto1_stream.sv
// N-channel valid/ready stream mux, fixed-select or round-robin, into a single output register.
// Latency: one cycle from input transfer to out_valid; one beat per cycle with out_ready high.
// Backpressure: in_ready only when the register is empty or draining. MUX_NTO1_STREAM_LAST_LOCK_EN holds grant to a channel until its last beat.
module mux_nto1_stream
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SW-1:0]   select,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic [SW-1:0]   out_sel,
    input  logic            out_ready
);

    logic          r_out_vld;
    logic [W-1:0]  r_out_dat;
    logic          r_out_last;
    logic [SW-1:0] r_out_sel;

    logic          w_load_en;
    logic          w_xfer;
    logic          w_advance;
    logic          w_lock_vld;
    logic [SW-1:0] w_lock_idx;
    logic [N-1:0]  w_lock_mask;
    logic [N-1:0]  w_fix_grant;
    logic [N-1:0]  w_arb_req;
    logic [N-1:0]  w_rr_grant;
    logic [SW-1:0] w_rr_idx;
    logic [N-1:0]  w_grant;
    logic [SW-1:0] w_src_idx;
    logic [W-1:0]  w_src_dat;
    logic          w_src_last;

`ifdef MUX_NTO1_STREAM_LAST_LOCK_EN
    logic          r_lock_vld;
    logic [SW-1:0] r_lock_idx;

    assign w_lock_vld = r_lock_vld;
    assign w_lock_idx = r_lock_idx;
`else
    assign w_lock_vld = 1'b0;
    assign w_lock_idx = '0;
`endif

    always_comb begin
        w_fix_grant = '0;
        w_lock_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (select == SW'(i)) w_fix_grant[i] = in_valid[i];
            w_lock_mask[i] = (w_lock_idx == SW'(i));
        end
    end

    // While locked the arbiter only sees the locked channel, so its index stays coherent.
    assign w_arb_req = w_lock_vld ? (in_valid & w_lock_mask) : in_valid;

    mux_rr_arbiter #(.N(N), .SW(SW)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (w_arb_req),
        .advance   (w_advance),
        .grant     (w_rr_grant),
        .grant_idx (w_rr_idx)
    );

    always_comb begin
        w_grant   = '0;
        w_src_idx = '0;
        if (N == 1) begin
            w_grant = in_valid;
        end else if (w_lock_vld) begin
            w_grant   = in_valid & w_lock_mask;
            w_src_idx = w_lock_idx;
        end else if (mode == MODE_RR) begin
            w_grant   = w_rr_grant;
            w_src_idx = w_rr_idx;
        end else begin
            w_grant   = w_fix_grant;
            w_src_idx = select;
        end
    end

    always_comb begin
        w_src_dat  = '0;
        w_src_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_src_dat  = in_data[i*W +: W];
                w_src_last = in_last[i];
            end
        end
    end

    assign w_load_en = !r_out_vld || out_ready;
    assign in_ready  = w_load_en ? w_grant : '0;
    assign w_xfer    = |in_ready;

`ifdef MUX_NTO1_STREAM_LAST_LOCK_EN
    assign w_advance = w_xfer && (mode == MODE_RR || w_lock_vld) && w_src_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_vld <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_xfer) begin
            r_lock_vld <= !w_src_last;
            r_lock_idx <= w_src_idx;
        end
    end
`else
    assign w_advance = w_xfer && (mode == MODE_RR);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_dat  <= '0;
            r_out_last <= 1'b0;
            r_out_sel  <= '0;
        end else if (w_load_en) begin
            if (w_xfer) begin
                r_out_vld  <= 1'b1;
                r_out_dat  <= w_src_dat;
                r_out_last <= w_src_last;
                r_out_sel  <= w_src_idx;
            end else if (out_ready) begin
                r_out_vld  <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_vld;
    assign out_data  = r_out_dat;
    assign out_last  = r_out_last;
    assign out_sel   = r_out_sel;

endmodule

// File: doc/mux_nto1_stream.md
# mux_nto1_stream

Parametrised N-channel, W-bit stream multiplexer that generalises the combinational 4:1 select mux. Each input channel has a valid/ready handshake. The output is registered through a single-entry pipeline stage. Channels are chosen either by an external select (fixed mode) or by round-robin arbitration (rr mode). It sits where several producers share one downstream consumer.

## Interface
Parameters:
- N, default 4: number of input channels, N ≥ 1.
- W, default 8: data width per channel, W ≥ 1.
- SW, default max(1, $clog2(N)): select width. Derived; never override.

Ports:
- clk, input, 1: single clock; all state changes on rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- mode, input, 1: 0 = fixed select, 1 = round-robin.
- select, input, SW: channel index used in fixed mode.
- in_valid, input, N: per-channel valid.
- in_data, input, N*W: channel i occupies bits [i*W +: W].
- in_last, input, N: per-channel end-of-packet marker.
- in_ready, output, N: per-channel accept.
- out_valid, output, 1: output register holds a beat.
- out_data, output, W: registered data.
- out_last, output, 1: registered last marker.
- out_sel, output, SW: index of the channel that produced the current beat.
- out_ready, input, 1: downstream accept.

## Operation
- Output transfer: out_valid && out_ready.
- Input transfer on channel i: in_valid[i] && in_ready[i].
- load_en = !out_valid || out_ready. The register can take a new beat when empty, or when it is draining in the same cycle.
- The grant is one-hot or zero and is computed combinationally each cycle.
  - Fixed mode: grant[select] = in_valid[select].
  - Fixed mode, select ≥ N: no grant.
- Round-robin mode:
  - Search starts at ptr+1 (mod N) and increments. The first valid channel wins.
  - ptr loads the winning index on each input transfer only.
- in_ready[i] = load_en && grant[i].
  - in_ready may depend combinationally on in_valid, mode, select and out_ready.
  - At most one bit of in_ready is set.
- On an input transfer from channel c:
  - out_data ← in_data[c].
  - out_last ← in_last[c].
  - out_sel ← c.
  - out_valid ← 1.
- With load_en set and no grant:
  - If out_ready is high, out_valid ← 0.
  - Otherwise the register holds.
- With load_en low (out_valid && !out_ready), all output registers hold their values.
- Mode or select changes take effect in the same cycle's grant. The beat already in the output register is unaffected.
- Boundaries:
  - N = 1: channel 0 is always granted when valid; select and mode are ignored.
  - All N channels valid continuously in rr mode: grant order 0,1,…,N−1,0,…

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, out_last = 0, out_sel = 0.
  - ptr = N−1, so channel 0 has priority first.
  - lock inactive.
  - in_ready settles to load_en && grant = grant, since out_valid = 0.
- Latency: one cycle from input transfer to out_valid.
- Throughput: one beat per cycle while out_ready is held high.
- Reset asserted mid-stream discards the registered beat and returns every register to its reset value immediately. The in-flight beat is lost.

## Configuration
Macro: MUX_NTO1_STREAM_LAST_LOCK_EN.

Defined (packet lock):
- An input transfer from channel c with in_last[c] = 0 sets lock to c.
- While locked, grant considers only channel c. Mode, select and the round-robin search are ignored.
- ptr is not updated until the in_last = 1 beat is transferred. That transfer clears the lock and sets ptr = c.
- Reset clears the lock.

Undefined:
- Arbitration is per beat.
- in_last is passed through to out_last with no effect on the grant.

## Structure
- Package mux_pkg:
  - Mode constants MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - Helper function sel_width(n) returning max(1, $clog2(n)).
- Sub-module mux_rr_arbiter:
  - Parameter N.
  - Inputs: req[N], advance.
  - Outputs: grant[N] (one-hot), grant_idx[SW].
  - Owns ptr; ptr updates when advance is high.
- The top level owns the output register, the fixed-mode grant, ready generation and the lock.

## Test plan
- Reset and empty: assert rst_n = 0 mid-traffic, with N = 4, W = 8. Required: out_valid, out_data, out_last and out_sel are 0 asynchronously; in_ready = 0 with no valid input.
- Fixed mode: mode = 0, select = 2, in_valid = 4'b1111, channel i data = 8'h10+i, out_ready = 1. Required: out_data = 8'h12 and out_sel = 2 every cycle; in_ready = 4'b0100.
- Round-robin fairness: mode = 1, all channels valid, out_ready = 1. Required: out_sel sequence 0,1,2,3,0,1 on consecutive cycles after one cycle of latency.
- Backpressure: hold out_ready = 0 for 3 cycles while out_valid = 1. Required: out_data and out_sel stable; in_ready = 0. Then raise out_ready. Required: the next beat loads in the same cycle, with no bubble.
- Boundary: select = 3 with in_valid[3] = 0, or N = 3 with select = 3. Required: in_ready = 0 and out_valid drops to 0 after the current beat drains.
- Lock, with MUX_NTO1_STREAM_LAST_LOCK_EN defined: rr mode; channel 1 sends 3 beats with last on the third; channel 2 is always valid. Required: out_sel = 1,1,1 and then 2; without the macro, out_sel alternates 1,2,1,2.
